// File: rtl/game_controller.sv
// Multimode counter game sequencer: steps the game counter, tallies all-ones/all-zeros hits,
// and raises winner/loser flags that freeze play until a restart clears the game.
//
// state | meaning
// IDLE  | waiting for start; everything holds
// RUN   | counting per ctrl, tallying hits
// END   | game decided; outputs frozen until restart
// CLEAR | one-cycle wipe of count, tallies and flags
module game_controller #(
   parameter int WIDTH     = 4,
   parameter int TALLY_W   = 4,
   parameter int TALLY_MAX = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               enable,
   input  logic [1:0]         ctrl,
   input  logic               init,
   input  logic [WIDTH-1:0]   init_value,
   input  logic               restart,
   output logic [WIDTH-1:0]   count,
   output logic [TALLY_W-1:0] winner_tally,
   output logic [TALLY_W-1:0] loser_tally,
   output logic               winner_flag,
   output logic               loser_flag,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_END   = 2'd2,
      S_CLEAR = 2'd3
   } state_t;

   localparam logic [TALLY_W-1:0] TMAX_LAST = TALLY_W'(TALLY_MAX - 1);

   state_t             state_q;
   logic [WIDTH-1:0]   count_q;
   logic [WIDTH-1:0]   count_d;
   logic [TALLY_W-1:0] win_tally_q;
   logic [TALLY_W-1:0] lose_tally_q;
   logic               win_flag_q;
   logic               lose_flag_q;

   // Modulo-2^WIDTH stepping falls out of the natural WIDTH-bit wrap.
   always_comb begin
      count_d = count_q;
      unique case (ctrl)
         2'b00: count_d = count_q + WIDTH'(1);
         2'b01: count_d = count_q + WIDTH'(2);
         2'b10: count_d = count_q - WIDTH'(1);
         2'b11: count_d = count_q - WIDTH'(2);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         count_q      <= '0;
         win_tally_q  <= '0;
         lose_tally_q <= '0;
         win_flag_q   <= 1'b0;
         lose_flag_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) state_q <= S_RUN;
            end
            S_RUN: begin
               if (init) begin
                  count_q <= init_value;
               end else if (enable) begin
                  count_q <= count_d;
                  if (count_d == '1) begin
                     win_tally_q <= win_tally_q + TALLY_W'(1);
                     if (win_tally_q == TMAX_LAST) begin
                        win_flag_q <= 1'b1;
                        state_q    <= S_END;
                     end
                  end else if (count_d == '0) begin
                     lose_tally_q <= lose_tally_q + TALLY_W'(1);
                     if (lose_tally_q == TMAX_LAST) begin
                        lose_flag_q <= 1'b1;
                        state_q     <= S_END;
                     end
                  end
               end
            end
            S_END: begin
               if (restart) state_q <= S_CLEAR;
            end
            S_CLEAR: begin
               count_q      <= '0;
               win_tally_q  <= '0;
               lose_tally_q <= '0;
               win_flag_q   <= 1'b0;
               lose_flag_q  <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign count        = count_q;
   assign winner_tally = win_tally_q;
   assign loser_tally  = lose_tally_q;
   assign winner_flag  = win_flag_q;
   assign loser_flag   = lose_flag_q;
   assign state        = state_q;

endmodule
